// File: rtl/ram_pkg.sv
// Shared types and the fill-pattern generator for ram_sp_init.
// No timing or backpressure of its own; used by the fill FSM.
package ram_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam logic [1:0] INIT_ZERO   = 2'd0;
    localparam logic [1:0] INIT_ONES   = 2'd1;
    localparam logic [1:0] INIT_DOUBLE = 2'd2;
    localparam logic [1:0] INIT_CONST  = 2'd3;

    // Wide enough for any practical word; callers keep the low DATA_W bits.
    localparam int PAT_W = 64;

    function automatic logic [PAT_W-1:0] pattern(
        input logic [1:0]       mode,
        input logic [PAT_W-1:0] value,
        input logic [PAT_W-1:0] index
    );
        logic [PAT_W-1:0] r;
        case (mode)
            INIT_ZERO:   r = '0;
            INIT_ONES:   r = '1;
            INIT_DOUBLE: r = index << 1;
            default:     r = value;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_init_fsm.sv
// Fill engine: one write per cycle for DEPTH cycles, then a one-cycle done pulse.
// No backpressure: the fill port always wins the RAM write port while busy.
module ram_init_fsm #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start,
    input  logic [1:0]        init_mode,
    input  logic [DATA_W-1:0] init_value,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              init_busy,
    output logic              init_done
);
    import ram_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              done_d;
    logic [PAT_W-1:0]  pat;
    logic              pat_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mode_q    <= INIT_ZERO;
            value_q   <= '0;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            value_q   <= value_d;
            init_done <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        value_d = value_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_start) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    mode_d  = init_mode;
                    value_d = init_value;
                end
            end
            FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign init_busy  = (state_q == FILL);
    assign fill_we    = init_busy;
    assign fill_addr  = cnt_q;
    assign pat        = pattern(mode_q, PAT_W'(value_q), PAT_W'(cnt_q));
    assign fill_data  = pat[DATA_W-1:0];
    assign pat_unused = ^pat[PAT_W-1:DATA_W];

endmodule

// File: rtl/ram_sp_init.sv
// Single-port RAM with registered read (1-cycle latency) and a built-in fill engine.
// No backpressure: host accesses during a fill, or colliding with init_start, are dropped.
module ram_sp_init #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    input  logic              init_start,
    input  logic [1:0]        init_mode,
    input  logic [DATA_W-1:0] init_value,
    output logic              init_busy,
    output logic              init_done
);
    import ram_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              host_ok;
    logic              addr_ok;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    ram_init_fsm #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .init_start(init_start),
        .init_mode (init_mode),
        .init_value(init_value),
        .fill_we   (fill_we),
        .fill_addr (fill_addr),
        .fill_data (fill_data),
        .init_busy (init_busy),
        .init_done (init_done)
    );

    // A start request in IDLE takes priority over a host access in the same cycle.
    assign host_ok = sel & ~init_busy & ~init_start;
    assign addr_ok = ({1'b0, addr} < DEPTH_L);

    always_comb begin
        we = 1'b0;
        wa = addr;
        wd = data_in;
        if (fill_we) begin
            we = 1'b1;
            wa = fill_addr;
            wd = fill_data;
        end else if (host_ok && write && addr_ok) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= host_ok & ~write;
            if (host_ok && !write) begin
                data_out <= addr_ok ? mem[addr] : '0;
            end
        end
    end

endmodule

// File: doc/ram_sp_init.md
# ram_sp_init

Parametrised synchronous single-port RAM with registered read and a built-in fill engine. It replaces the combinational 1024x8 RAM in the memory-modelling library. A single `init_start` pulse fills every location with a selectable pattern, so benches and designs do not need a 1024-iteration software write loop. It sits behind any master using the existing `sel`/`write` access style.

## Interface
- `DATA_W`, 8: data width in bits.
- `ADDR_W`, 10: address width in bits.
- `DEPTH`, 1<<ADDR_W: number of words. Must satisfy 2 ≤ DEPTH ≤ 2^ADDR_W.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sel`  in  1  access request.
- `write`  in  1  1 = write, 0 = read. Only meaningful while `sel`=1.
- `addr`  in  ADDR_W  word address.
- `data_in`  in  DATA_W  write data.
- `data_out`  out  DATA_W  registered read data.
- `rd_valid`  out  1  `data_out` holds the result of a read sampled on the previous edge.
- `init_start`  in  1  start-fill request. Level-sampled, acted on only in IDLE.
- `init_mode`  in  2  fill pattern, captured with `init_start`:
  - 0: zeros
  - 1: all ones
  - 2: (2*a) mod 2^DATA_W
  - 3: `init_value`
- `init_value`  in  DATA_W  constant for mode 3, captured with `init_start`.
- `init_busy`  out  1  fill in progress.
- `init_done`  out  1  one-cycle pulse on fill completion.

## Operation
- Reset values:
  - `data_out`=0, `rd_valid`=0, `init_busy`=0, `init_done`=0.
  - FSM = IDLE, fill counter = 0.
  - Array contents are not cleared by reset.
- FSM states:
  - IDLE → FILL when `init_start`=1. Captures `init_mode`/`init_value`, counter=0.
  - FILL: writes mem[cnt]=pattern(cnt), cnt++ each cycle. The cycle cnt==DEPTH-1 performs the last write and goes to IDLE.
- Host access in IDLE:
  - `sel`=1, `write`=1: mem[addr]←data_in. `rd_valid`=0 next cycle; `data_out` holds its value.
  - `sel`=1, `write`=0: `data_out`←mem[addr], `rd_valid`=1 next cycle.
  - `sel`=0: `rd_valid`=0 next cycle; `data_out` holds.
- Read-after-write to the same address on consecutive cycles returns the new data (no bypass needed; the write lands first).
- Host accesses while `init_busy`=1 are ignored: no write, `rd_valid`=0.
- `init_start` and `sel` both high in IDLE: the fill wins and the host access is dropped.
- `init_start` while FILL: ignored.
- `addr` ≥ DEPTH (non-power-of-2 DEPTH): writes dropped, reads return 0 with `rd_valid`=1.
- Pattern arithmetic: mode 2 uses a counter zero-extended/truncated to DATA_W, shifted left 1, truncated to DATA_W.
- `rst` mid-fill: FSM returns to IDLE immediately, `init_busy`=0, no `init_done`. Already-written words keep their new values; the rest keep old contents.

## Timing
- Read latency: 1 cycle, from the edge sampling `sel`/`addr` to valid `data_out`.
- Fill sampled at edge N:
  - `init_busy`=1 after edge N through edge N+DEPTH.
  - Writes occur at edges N+1 … N+DEPTH.
  - After edge N+DEPTH: `init_busy`=0 and `init_done`=1 for exactly one cycle.
  - Fill takes DEPTH cycles of busy.
- A new `init_start` is accepted during the `init_done` cycle (FSM is IDLE).
- Host accesses are accepted again on the first IDLE cycle.

## Structure
- Package `ram_pkg`:
  - FSM state enum (IDLE, FILL).
  - `init_mode` constants: INIT_ZERO, INIT_ONES, INIT_DOUBLE, INIT_CONST.
  - Pattern function pattern(mode, value, index).
- Sub-module `ram_init_fsm`: FSM, counter, captured mode/value. Outputs the write enable, address and data for the fill port, plus `init_busy`/`init_done`.
- Top level holds the array, the host/fill write-port mux and the read register.

## Test plan
- Reset, then mode 2 fill with DEPTH=1024, DATA_W=8 → `init_busy` high 1024 cycles, one `init_done` pulse; read addr 0→0, 1→2, 127→254, 128→0, 1023→254.
- Mode 3 with `init_value`=0xA5, then host write 0x3C to addr 5, read addr 5 next cycle → 0x3C with `rd_valid`=1 one cycle after read issue; addr 6 → 0xA5.
- `sel`=1, `write`=1, addr 10 during FILL → ignored; after done, addr 10 reads the pattern value. `init_start` during FILL → no restart, done still pulses at the original time.
- Assert `rst` 300 cycles into a mode 1 fill over a prior mode 0 fill → outputs 0, no `init_done`; addr 0..299 read 0xFF, addr 300..1023 read 0x00.
- DEPTH=1000, ADDR_W=10: fill takes 1000 cycles; write to addr 1010 dropped; reading addr 1010 → 0 with `rd_valid`=1.
